// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: state encodings and default timing constants for the stall controller
package pipeline_stall_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_FLUSH  = 2'b10,
    ST_HALTED = 2'b11
  } ctrl_state_t;
  localparam int FLUSH_LEN_DEF = 1;
  localparam int MAX_STALL_DEF = 4;
endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: pipeline write-enable/squash/bubble control, stall watchdog and
// optional perf counters (enabled by defining PIPE_PERF_CNT_EN)
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int FLUSH_LEN = FLUSH_LEN_DEF,
  parameter int MAX_STALL = MAX_STALL_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             halt,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic [1:0]       ctrlState,
  output logic             stallErr,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);
  ctrl_state_t state, state_nxt;
  logic [2:0]  sq, sq_nxt;
  logic [3:0]  cons;
  logic        stall_hit, bub_cnt;
  always_comb begin
    state_nxt  = state;
    sq_nxt     = sq;
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    stall_hit  = 1'b0;
    bub_cnt    = 1'b0;
    if (flush) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
      state_nxt  = (FLUSH_LEN == 0) ? ST_RUN : ST_FLUSH;
      sq_nxt     = 3'(FLUSH_LEN);
    end else if (state == ST_FLUSH) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
      state_nxt  = (sq <= 3'd1) ? ST_RUN : ST_FLUSH;
      sq_nxt     = sq - 3'd1;
    end else if (state == ST_HALTED) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      bub_cnt    = 1'b1;
    end else if (stall) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      stall_hit  = 1'b1;
      bub_cnt    = 1'b1;
      state_nxt  = ST_STALL;
    end else if (halt) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      state_nxt  = ST_HALTED;
    end else begin
      state_nxt  = ST_RUN;
    end
  end
  // any cycle without an honoured stall breaks the consecutive run
  sat_counter #(.W(4)) u_cons (.clk, .rst, .inc(stall_hit), .clr(!stall_hit), .q(cons));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= ST_RUN;
      sq       <= '0;
      stallErr <= 1'b0;
    end else begin
      state    <= state_nxt;
      sq       <= sq_nxt;
      stallErr <= stallErr | (stall_hit && cons >= 4'(MAX_STALL - 1));
    end
  assign ctrlState = state;
`ifdef PIPE_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_scnt (.clk, .rst, .inc(bub_cnt), .clr(1'b0), .q(stallCount));
  sat_counter #(.W(CNT_W)) u_fcnt (.clk, .rst, .inc(flush), .clr(1'b0), .q(flushCount));
`else
  logic unused_bub;
  assign unused_bub = bub_cnt;
  assign stallCount = '0;
  assign flushCount = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed and randomized checks of pipeline_stall_ctrl against a behavioural model
module tb_pipeline_stall_ctrl;
  localparam int FL    = 1;
  localparam int MAXS  = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  logic clk, rst, stall, flush, halt;
  logic pcWrite, ifidWrite, ifidFlush, idexBubble, stallErr;
  logic [1:0] ctrlState;
  logic [CNT_W-1:0] stallCount, flushCount;
  int errors = 0, checks = 0;
  bit cmp_en = 0;
  int m_mode, m_sq, m_cons, m_err, m_sc, m_fc;

  pipeline_stall_ctrl #(.FLUSH_LEN(FL), .MAX_STALL(MAXS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .halt(halt),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush), .idexBubble(idexBubble),
    .ctrlState(ctrlState), .stallErr(stallErr), .stallCount(stallCount), .flushCount(flushCount)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // reference model: modes 0 run, 1 stall, 2 flush, 3 halted
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_mode <= 0; m_sq <= 0; m_cons <= 0; m_err <= 0; m_sc <= 0; m_fc <= 0;
    end else if (flush) begin
      m_mode <= (FL == 0) ? 0 : 2;
      m_sq   <= FL;
      m_cons <= 0;
      m_fc   <= (m_fc >= CMAX) ? CMAX : m_fc + 1;
    end else if (m_mode == 2) begin
      if (m_sq <= 1) m_mode <= 0;
      else m_sq <= m_sq - 1;
    end else if (m_mode == 3) begin
      m_sc <= (m_sc >= CMAX) ? CMAX : m_sc + 1;
    end else if (stall) begin
      m_mode <= 1;
      m_cons <= (m_cons >= 15) ? 15 : m_cons + 1;
      if (m_cons + 1 >= MAXS) m_err <= 1;
      m_sc   <= (m_sc >= CMAX) ? CMAX : m_sc + 1;
    end else if (halt) begin
      m_mode <= 3; m_cons <= 0;
    end else begin
      m_mode <= 0; m_cons <= 0;
    end

  always @(negedge clk)
    if (cmp_en) begin
      logic [3:0] e;
      e = flush ? 4'b1111 : (m_mode == 2) ? 4'b1111 : (m_mode == 3) ? 4'b0001 :
          stall ? 4'b0001 : halt ? 4'b0000 : 4'b1100;
      chk("ctrl_outs", {28'd0, pcWrite, ifidWrite, ifidFlush, idexBubble}, {28'd0, e});
      chk("ctrlState", {30'd0, ctrlState}, m_mode);
      chk("stallErr", {31'd0, stallErr}, m_err);
`ifdef PIPE_PERF_CNT_EN
      chk("stallCount", {{(32-CNT_W){1'b0}}, stallCount}, m_sc);
      chk("flushCount", {{(32-CNT_W){1'b0}}, flushCount}, m_fc);
`else
      chk("stallCount", {{(32-CNT_W){1'b0}}, stallCount}, 0);
      chk("flushCount", {{(32-CNT_W){1'b0}}, flushCount}, 0);
`endif
    end

  task automatic cyc(input bit s, input bit f, input bit h);
    @(posedge clk); #1;
    stall = s; flush = f; halt = h;
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    stall = 0; flush = 0; halt = 0; rst = 1;
    #2;
    chk("reset_outs", {28'd0, pcWrite, ifidWrite, ifidFlush, idexBubble}, 32'b1100);
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; halt = 0;
    #1 cmp_en = 1;
    do_reset();
    repeat (5) cyc(0, 0, 0);
    chk("idle_state", ctrlState, 0);
    chk("idle_pc", pcWrite, 1);
    chk("idle_cnt", stallCount, 0);
    // single load-use stall
    cyc(1, 0, 0);
    chk("ld_pc", pcWrite, 0);
    chk("ld_bub", idexBubble, 1);
    cyc(0, 0, 0);
    chk("ld_state", ctrlState, 1);
    cyc(0, 0, 0);
    chk("ld_back", ctrlState, 0);
`ifdef PIPE_PERF_CNT_EN
    chk("ld_scnt", stallCount, 1);
`else
    chk("ld_scnt", stallCount, 0);
`endif
    // stall and flush together
    do_reset();
    cyc(1, 1, 0);
    chk("sf_outs", {pcWrite, ifidFlush, idexBubble}, 3'b111);
    cyc(1, 0, 0);
    chk("sf_state", ctrlState, 2);
    chk("sf_pc", pcWrite, 1);
    cyc(0, 0, 0);
    chk("sf_run", ctrlState, 0);
`ifdef PIPE_PERF_CNT_EN
    chk("sf_fcnt", flushCount, 1);
`else
    chk("sf_fcnt", flushCount, 0);
`endif
    chk("sf_scnt", stallCount, 0);
    // watchdog: 3 stalls safe, 4 stalls trip
    do_reset();
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("wd3_err", stallErr, 0);
    repeat (4) cyc(1, 0, 0);
    chk("wd4_pre", stallErr, 0);
    cyc(0, 0, 0);
    chk("wd4_err", stallErr, 1);
    repeat (3) cyc(0, 0, 0);
    chk("wd4_sticky", stallErr, 1);
    // halt, hold, flush out
    do_reset();
    cyc(0, 0, 1);
    repeat (10) begin
      cyc(0, 0, 0);
      chk("halt_state", ctrlState, 3);
      chk("halt_pc_bub", {pcWrite, idexBubble}, 2'b01);
    end
    cyc(0, 1, 0);
    chk("halt_flush", ifidFlush, 1);
    cyc(0, 0, 0);
    chk("halt_fl_state", ctrlState, 2);
    cyc(0, 0, 0);
    chk("halt_run", ctrlState, 0);
    // asynchronous reset while halted
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("ahalt_state", ctrlState, 3);
    rst = 1;
    #1;
    chk("arst_state", ctrlState, 0);
    chk("arst_pc", pcWrite, 1);
    @(posedge clk); #1;
    rst = 0;
    // counter saturation
    do_reset();
    repeat (20) cyc(1, 0, 0);
    cyc(0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
    chk("sat_scnt", stallCount, 15);
`else
    chk("sat_scnt", stallCount, 0);
`endif
    chk("sat_err", stallErr, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 5) do_reset();
      else cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4);
    end
    cyc(0, 0, 0);
    @(posedge clk); #1;
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Consumer end of the hazard-detection stall interface. Takes the decode-stage `stall`, the execute-stage redirect (`flush`) and decoded HALT. Drives the pipeline write-enables and bubble/squash controls: PC, IF/ID and ID/EX. Also owns the stall watchdog and the optional performance counters; sits beside the hazard detection unit in the processor top.

Parameters:
- FLUSH_LEN, 1, extra cycles after a redirect during which IF/ID stays squashed (covers fetch latency); legal 0..7.
- MAX_STALL, 4, consecutive stall cycles at which the watchdog error sets; legal 2..15.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  from hazard detection unit; valid for the instruction in ID this cycle
- flush  in  1  branch/jump taken, resolved in EX; PC redirect this cycle
- halt  in  1  HALT decoded in ID
- pcWrite  out  1  PC register write enable
- ifidWrite  out  1  IF/ID register write enable
- ifidFlush  out  1  IF/ID loads NOP
- idexBubble  out  1  ID/EX loads NOP (control bits zeroed)
- ctrlState  out  2  current FSM state
- stallErr  out  1  sticky watchdog error
- stallCount  out  CNT_W  total stall cycles (saturating)
- flushCount  out  CNT_W  total redirects (saturating)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state:
  - state RUN (2'b00), stallErr=0, counters=0, internal counters=0.
  - Outputs during reset: pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0.
- Control outputs are combinational from state and inputs (same-cycle effect). State and counters update on posedge clk.
- States: RUN=00, STALL=01, FLUSH=10, HALTED=11.
- Priority every cycle: flush > (state FLUSH squash) > halt state > stall > normal.
- flush=1, any state:
  - pcWrite=1, ifidWrite=1, ifidFlush=1, idexBubble=1.
  - Next state FLUSH with squash counter loaded to FLUSH_LEN. If FLUSH_LEN=0, next state is RUN.
  - Consecutive-stall counter clears.
  - A flush in HALTED leaves HALTED: the HALT was on the wrong path.
- FLUSH state:
  - pcWrite=1, ifidWrite=1, ifidFlush=1, idexBubble=1.
  - stall and halt are ignored (the ID instruction is squashed).
  - Counter decrements; on reaching 1, next state is RUN.
- RUN/STALL with stall=1:
  - pcWrite=0, ifidWrite=0, ifidFlush=0, idexBubble=1.
  - Next state STALL; consecutive counter increments, saturating at 15.
- RUN/STALL with stall=0, halt=1:
  - pcWrite=0, ifidWrite=0, idexBubble=0 (HALT proceeds down the pipe).
  - Next state HALTED.
- RUN/STALL, no inputs: all enables 1, squash/bubble 0; next state RUN; consecutive counter clears.
- HALTED without flush:
  - pcWrite=0, ifidWrite=0, ifidFlush=0, idexBubble=1.
  - State holds until reset.
- Watchdog: when the consecutive counter reaches MAX_STALL (counted on the cycle the stall is asserted), stallErr sets and stays set until rst. Stalls keep being honoured.
- Counters (under macro):
  - stallCount increments each cycle idexBubble=1 due to stall, or due to HALTED.
  - flushCount increments once per cycle flush=1.
  - Both saturate at all-ones and never wrap.
- rst asserted mid-stall or mid-flush: immediate return to RUN with all reset values, no partial squash carried.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: stallCount and flushCount are implemented as above.
- Undefined: both outputs are tied to 0 and no counter flops exist. FSM, watchdog and control outputs are unchanged.

Decomposition:
- Shared package/include holds:
  - state encodings ST_RUN/ST_STALL/ST_FLUSH/ST_HALTED (2 bits);
  - default FLUSH_LEN and MAX_STALL constants.
- One sub-module is natural: sat_counter (parameterised width, inc, clr, async active-high rst). It is reused for both performance counters and the consecutive-stall counter.

Test Plan:
- Reset then idle 5 cycles -> pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0, ctrlState=00, counters 0.
- Single-cycle stall (load-use) -> that cycle pcWrite=0, ifidWrite=0, idexBubble=1; next cycle ctrlState=01; after deassert, back to 00; stallCount=1.
- stall and flush in the same cycle, FLUSH_LEN=1 -> pcWrite=1, ifidFlush=1, idexBubble=1.
  - Next cycle: ctrlState=10 with stall=1 ignored (pcWrite=1).
  - Then RUN; flushCount=1, stallCount=0.
- stall held 4 cycles, MAX_STALL=4 -> stallErr rises on the edge after the 4th stall cycle and stays 1 after stall drops; a 3-cycle stall never sets it.
- halt=1 -> next cycle ctrlState=11, pcWrite=0, idexBubble=1 held 10 cycles.
  - Then flush=1 -> ctrlState=10, then 00.
  - Separately, rst during HALTED -> 00 immediately (asynchronous).
- Build without PIPE_PERF_CNT_EN, repeat the stall test -> stallCount=flushCount=0; controls identical.
- Build with PIPE_PERF_CNT_EN and CNT_W=4, then run 20 stall cycles -> stallCount saturates at 15.
